// File: rtl/rv32_muldiv_pkg.sv
// Shared RV32M encodings, widths and the mul/div unit state type.
package rv32_muldiv_pkg;
  localparam int unsigned RegWidth     = 32;
  localparam int unsigned RegAddrWidth = 5;

  localparam logic [2:0] OpF3MUL    = 3'b000;
  localparam logic [2:0] OpF3MULH   = 3'b001;
  localparam logic [2:0] OpF3MULHSU = 3'b010;
  localparam logic [2:0] OpF3MULHU  = 3'b011;
  localparam logic [2:0] OpF3DIV    = 3'b100;
  localparam logic [2:0] OpF3DIVU   = 3'b101;
  localparam logic [2:0] OpF3REM    = 3'b110;
  localparam logic [2:0] OpF3REMU   = 3'b111;

  typedef enum logic [1:0] {MdIdle, MdMul, MdDiv, MdDone} muldiv_state_e;
endpackage

// File: rtl/rv32_div_core.sv
// Iterative restoring radix-2 unsigned divider: one quotient bit per clock.
module rv32_div_core #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         kill,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);
  localparam int unsigned CW = $clog2(W);

  logic [W-1:0]  dvd;
  logic [W-1:0]  dvs;
  logic [W-1:0]  rem;
  logic [CW-1:0] cnt;
  logic [W:0]    trial;
  logic          take;

  // Quotient bits shift into dvd from the bottom as dividend bits leave the top.
  always_comb begin
    trial = {rem, dvd[W-1]};
    take  = (trial >= {1'b0, dvs});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd  <= '0;
      dvs  <= '0;
      rem  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (kill) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        dvd  <= dividend;
        dvs  <= divisor;
        rem  <= '0;
        cnt  <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        rem <= take ? (trial[W-1:0] - dvs) : trial[W-1:0];
        dvd <= {dvd[W-2:0], take};
        cnt <= cnt + 1'b1;
        if (cnt == CW'(W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient  = dvd;
  assign remainder = rem;
endmodule

// File: rtl/rv32_muldiv.sv
// RV32M execute unit: two-cycle multiply, iterative divide, tagged valid/ready result.
module rv32_muldiv
  import rv32_muldiv_pkg::*;
#(
  parameter int unsigned XLEN    = RegWidth,
  parameter int unsigned RegAddr = RegAddrWidth
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [2:0]         i_funct3,
  input  logic [XLEN-1:0]    i_rs1,
  input  logic [XLEN-1:0]    i_rs2,
  input  logic [RegAddr-1:0] i_rd,
  input  logic               i_flush,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [XLEN-1:0]    o_result,
  output logic [RegAddr-1:0] o_rd
);
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e state, stateNext;

  logic [2:0]      funct3Q;
  logic [XLEN-1:0] opA, opB;
  logic            qNeg, rNeg;

  logic            accept, isMul, divSigned, isRem, divByZero, divOvf, divSpecial, divStart;
  logic [XLEN-1:0] specialRes, absA, absB;
  logic            aSign, bSign;
  logic [2*XLEN-1:0] aExt, bExt, product;
  logic [XLEN-1:0] mulRes, quotFix, remFix, divRes;
  logic            divBusy, divDone;
  logic [XLEN-1:0] divQ, divR;

  always_comb begin
    accept     = (state == MdIdle) && i_valid && !i_flush;
    isMul      = i_funct3 inside {OpF3MUL, OpF3MULH, OpF3MULHSU, OpF3MULHU};
    divSigned  = i_funct3 inside {OpF3DIV, OpF3REM};
    isRem      = i_funct3 inside {OpF3REM, OpF3REMU};
    divByZero  = (i_rs2 == '0);
    divOvf     = divSigned && (i_rs1 == MinInt) && (i_rs2 == '1);
    divSpecial = divByZero || divOvf;
    divStart   = accept && !isMul && !divSpecial;
    if (divByZero) specialRes = isRem ? i_rs1 : '1;
    else           specialRes = isRem ? '0 : MinInt;
    absA = (divSigned && i_rs1[XLEN-1]) ? -i_rs1 : i_rs1;
    absB = (divSigned && i_rs2[XLEN-1]) ? -i_rs2 : i_rs2;
  end

  // 33-bit signed/unsigned operand semantics realised by extending to full product width.
  always_comb begin
    aSign   = opA[XLEN-1] && (funct3Q inside {OpF3MULH, OpF3MULHSU});
    bSign   = opB[XLEN-1] && (funct3Q == OpF3MULH);
    aExt    = {{XLEN{aSign}}, opA};
    bExt    = {{XLEN{bSign}}, opB};
    product = aExt * bExt;
    mulRes  = (funct3Q == OpF3MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    quotFix = qNeg ? -divQ : divQ;
    remFix  = rNeg ? -divR : divR;
    divRes  = (funct3Q inside {OpF3REM, OpF3REMU}) ? remFix : quotFix;
  end

  always_comb begin
    stateNext = state;
    case (state)
      MdIdle: if (accept) stateNext = isMul ? MdMul : (divSpecial ? MdDone : MdDiv);
      MdMul:  stateNext = MdDone;
      MdDiv: begin
        if (divDone)       stateNext = MdDone;
        else if (!divBusy) stateNext = MdIdle;
      end
      MdDone: if (i_ready) stateNext = MdIdle;
      default: stateNext = MdIdle;
    endcase
    if (i_flush) stateNext = MdIdle;
    o_ready = (state == MdIdle);
    o_valid = (state == MdDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MdIdle;
    else        state <= stateNext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3Q  <= '0;
      opA      <= '0;
      opB      <= '0;
      qNeg     <= 1'b0;
      rNeg     <= 1'b0;
      o_result <= '0;
      o_rd     <= '0;
    end else if (accept) begin
      funct3Q <= i_funct3;
      opA     <= i_rs1;
      opB     <= i_rs2;
      qNeg    <= divSigned && (i_rs1[XLEN-1] ^ i_rs2[XLEN-1]);
      rNeg    <= divSigned && i_rs1[XLEN-1];
      o_rd    <= i_rd;
      if (!isMul && divSpecial) o_result <= specialRes;
    end else if (state == MdMul) begin
      o_result <= mulRes;
    end else if (state == MdDiv && divDone) begin
      o_result <= divRes;
    end
  end

  rv32_div_core #(.W(XLEN)) uDiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .kill      (i_flush),
    .start     (divStart),
    .dividend  (absA),
    .divisor   (absB),
    .busy      (divBusy),
    .done      (divDone),
    .quotient  (divQ),
    .remainder (divR)
  );
endmodule

// File: tb/tb_rv32_muldiv.sv
// Scoreboard bench for rv32_muldiv: directed M-ops, handshake stall, flush and reset abort.
module tb_rv32_muldiv;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_ready = 1'b1;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_rs1 = '0;
  logic [31:0] i_rs2 = '0;
  logic [4:0]  i_rd = '0;
  logic        o_ready, o_valid;
  logic [31:0] o_result;
  logic [4:0]  o_rd;

  rv32_muldiv #(.XLEN(32), .RegAddr(5)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_funct3(i_funct3), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_rd(o_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  exp_t mexp;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every retiring result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected result: got %h rd %0d expected none", o_result, o_rd);
      end else begin
        mexp = sb.pop_front();
        chk({mexp.name, " result"}, o_result, mexp.res);
        chk({mexp.name, " rd"}, 32'(o_rd), 32'(mexp.rd));
      end
    end
  end

  // Called #1 after a rising edge. lat < 0 skips the latency check.
  task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] res,
                       input int lat, input bit push);
    int n = 0;
    while (!o_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!o_ready) begin
      chk({name, " ready timeout"}, 32'(o_ready), 32'd1);
      return;
    end
    i_valid = 1'b1; i_funct3 = f3; i_rs1 = a; i_rs2 = b; i_rd = rd;
    if (push) sb.push_back('{name, res, rd});
    @(posedge clk); #1;
    i_valid = 1'b0;
    if (lat >= 0) begin
      n = 0;
      while (!o_valid && n < 100) begin
        @(posedge clk); #1; n++;
      end
      chk({name, " latency"}, 32'(n), 32'(lat));
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (o_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk({name, " retired"}, 32'(o_valid), 32'd0);
  endtask

  task automatic watchQuiet(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (o_valid) seen++;
    end
    chk({name, " o_valid stays low"}, 32'(seen), 32'd0);
  endtask

  initial begin
    #2;
    chk("reset o_ready", 32'(o_ready), 32'd1);
    chk("reset o_valid", 32'(o_valid), 32'd0);
    chk("reset o_result", o_result, 32'd0);
    chk("reset o_rd", 32'(o_rd), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    issue("MUL", 3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 1, 1'b1);        drain("MUL");
    issue("MULH", 3'b001, 32'h80000000, 32'h80000000, 5'd6, 32'h40000000, 1, 1'b1); drain("MULH");
    issue("MULHU", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFE, 1, 1'b1); drain("MULHU");
    issue("MULHSU", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFF, 1, 1'b1); drain("MULHSU");

    issue("DIV", 3'b100, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFD, 33, 1'b1);  drain("DIV");
    issue("REM", 3'b110, 32'hFFFFFFF9, 32'd2, 5'd11, 32'hFFFFFFFF, 33, 1'b1);  drain("REM");
    issue("DIVU", 3'b101, 32'd100, 32'd7, 5'd12, 32'd14, 33, 1'b1);           drain("DIVU");
    issue("REMU", 3'b111, 32'd100, 32'd7, 5'd13, 32'd2, 33, 1'b1);            drain("REMU");
    issue("REM neg divisor", 3'b110, 32'd7, 32'hFFFFFFFE, 5'd14, 32'd1, 33, 1'b1); drain("REM neg divisor");

    issue("DIV by 0", 3'b100, 32'd5, 32'd0, 5'd15, 32'hFFFFFFFF, 0, 1'b1);    drain("DIV by 0");
    issue("REMU by 0", 3'b111, 32'd5, 32'd0, 5'd16, 32'd5, 0, 1'b1);          drain("REMU by 0");
    issue("DIV ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 0, 1'b1); drain("DIV ovf");
    issue("REM ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'd0, 0, 1'b1); drain("REM ovf");

    // Writeback stall: result must hold while i_ready is low.
    i_ready = 1'b0;
    issue("hold MULHU", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 32'hFFFFFFFE, 1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold o_result", o_result, 32'hFFFFFFFE);
      chk("hold o_rd", 32'(o_rd), 32'd9);
      chk("hold o_ready", 32'(o_ready), 32'd0);
      chk("hold o_valid", 32'(o_valid), 32'd1);
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    chk("release o_valid", 32'(o_valid), 32'd0);
    chk("release o_ready", 32'(o_ready), 32'd1);

    // Flush ten edges into a divide.
    issue("flush DIVU", 3'b101, 32'd1000, 32'd3, 5'd1, 32'd0, -1, 1'b0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    chk("flush o_ready", 32'(o_ready), 32'd1);
    chk("flush o_valid", 32'(o_valid), 32'd0);
    watchQuiet("after flush", 40);

    // Asynchronous reset mid-divide.
    issue("reset DIV", 3'b100, 32'd1000, 32'd7, 5'd2, 32'd0, -1, 1'b0);
    repeat (15) begin
      @(posedge clk); #1;
    end
    #3 rst_n = 1'b0;
    #1;
    chk("midreset o_valid", 32'(o_valid), 32'd0);
    chk("midreset o_ready", 32'(o_ready), 32'd1);
    chk("midreset o_result", o_result, 32'd0);
    chk("midreset o_rd", 32'(o_rd), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    watchQuiet("after reset", 40);

    issue("DIVU 9/3", 3'b101, 32'd9, 32'd3, 5'd3, 32'd3, 33, 1'b1);
    drain("DIVU 9/3");
    chk("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
